sigmoid_horner_eval: RTL and testbench

Sequential sigmoid evaluator. It is the requesting side of the segment-indexed MacLaurin coefficient lookups (term1/term2/term3 LUTs, 3-bit index in, 16-bit signed coefficient out). The block takes a 16-bit signed Q8.8 activation, drives the segment index to the three LUTs, and evaluates y = t1 + d*(t2 + d*t3) on one shared multiplier. It returns sigmoid(x) in Q8.8 through a valid/ready handshake, and sits between the MAC array and the next neuron layer.

---
 rtl/sigmoid_horner_eval_pkg.sv | 17 +
 rtl/sigmoid_horner_eval_if.sv | 29 ++
 rtl/sigmoid_horner_eval_fxp_mul.sv | 16 +
 rtl/sigmoid_horner_eval.sv | 128 ++++++++++++
 tb/tb_sigmoid_horner_eval.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_horner_eval_pkg.sv
// rtl/sigmoid_horner_eval_pkg.sv - shared constants and FSM encoding for the sigmoid evaluator
package sigmoid_pkg;

  localparam int FRAC    = 8;
  localparam int ONE     = 1 << FRAC;
  localparam int SAT_INT = 6;
  localparam int SEG_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    EVAL1,
    EVAL2,
    FINAL,
    DONE
  } state_e;

endpackage

// File: rtl/sigmoid_horner_eval_if.sv
// rtl/sigmoid_horner_eval_if.sv - activation in, coefficient LUT lookup and sigmoid out bundle
// master is the surrounding fabric (MAC array, LUTs, next layer); slave is the evaluator.
interface sigmoid_horner_eval_if #(
  parameter int W = 16
);
  import sigmoid_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     x_in;
  logic [SEG_W-1:0]        seg_idx;
  logic signed [W-1:0]     t1;
  logic signed [W-1:0]     t2;
  logic signed [W-1:0]     t3;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W-1:0]     y_out;

  modport master (
    output in_valid, x_in, t1, t2, t3, out_ready,
    input  in_ready, seg_idx, out_valid, y_out
  );

  modport slave (
    input  in_valid, x_in, t1, t2, t3, out_ready,
    output in_ready, seg_idx, out_valid, y_out
  );

endinterface

// File: rtl/sigmoid_horner_eval_fxp_mul.sv
// rtl/sigmoid_horner_eval_fxp_mul.sv - signed fixed-point multiply, floor-rescaled and truncated to W
module fxp_mul #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] p_o
);

  logic signed [2*W-1:0] prod;

  assign prod = a_i * b_i;
  assign p_o  = W'(prod >>> FRAC);

endmodule

// File: rtl/sigmoid_horner_eval.sv
// rtl/sigmoid_horner_eval.sv - sequential sigmoid via segment LUTs and Horner form on one multiplier
// y = t1 + d*(t2 + d*t3), mirrored for negative inputs as 1 - sigmoid(|x|).
module sigmoid_horner_eval #(
  parameter int W       = 16,
  parameter int FRAC    = sigmoid_pkg::FRAC,
  parameter int SAT_INT = sigmoid_pkg::SAT_INT
) (
  input logic                  clk,
  input logic                  rst_n,
  sigmoid_horner_eval_if.slave bus
);
  import sigmoid_pkg::*;

  localparam logic signed [W-1:0] ONE_W  = W'(1 << FRAC);
  localparam logic [W-1:0]        AX_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        X_MIN  = {1'b1, {(W-1){1'b0}}};

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic                sat_q, sat_d;
  logic                out_valid_q, out_valid_d;
  logic signed [W-1:0] dlt_q, dlt_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic signed [W-1:0] acc2_q, acc2_d;
  logic signed [W-1:0] y_q, y_d;
  logic [SEG_W-1:0]    seg_q, seg_d;

  logic [W-1:0]        ax, ip, base;
  logic                in_sat;
  logic signed [W-1:0] mul_b, mul_p, clip_p;

  // Segments 4 and 5 share the expansion point 4.0, so base clamps at 4.
  always_comb begin
    if (!bus.x_in[W-1])        ax = bus.x_in;
    else if (bus.x_in == X_MIN) ax = AX_MAX;
    else                        ax = -bus.x_in;
    ip     = ax >> FRAC;
    in_sat = (ip >= W'(SAT_INT));
    base   = ((ip > W'(4)) ? W'(4) : ip) << FRAC;
  end

  assign mul_b = (state_q == EVAL2) ? acc_q : bus.t3;

  fxp_mul #(.W(W), .FRAC(FRAC)) u_mul (
    .a_i (dlt_q),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    if (sat_q || (acc2_q > ONE_W)) clip_p = ONE_W;
    else if (acc2_q[W-1])          clip_p = '0;
    else                           clip_p = acc2_q;
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    sat_d       = sat_q;
    dlt_d       = dlt_q;
    seg_d       = seg_q;
    acc_d       = acc_q;
    acc2_d      = acc2_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.x_in[W-1];
          sat_d   = in_sat;
          dlt_d   = ax - base;
          seg_d   = in_sat ? '0 : ip[SEG_W-1:0];
          state_d = EVAL1;
        end
      end
      EVAL1: begin
        acc_d   = bus.t2 + mul_p;
        state_d = EVAL2;
      end
      EVAL2: begin
        acc2_d  = bus.t1 + mul_p;
        state_d = FINAL;
      end
      FINAL: begin
        y_d         = sign_q ? (ONE_W - clip_p) : clip_p;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      sat_q       <= 1'b0;
      dlt_q       <= '0;
      seg_q       <= '0;
      acc_q       <= '0;
      acc2_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      sat_q       <= sat_d;
      dlt_q       <= dlt_d;
      seg_q       <= seg_d;
      acc_q       <= acc_d;
      acc2_q      <= acc2_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y_out     = y_q;
  assign bus.seg_idx   = seg_q;

endmodule

// File: tb/tb_sigmoid_horner_eval.sv
// tb/tb_sigmoid_horner_eval.sv - self-checking bench for sigmoid_horner_eval
module tb_sigmoid_horner_eval;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sigmoid_horner_eval_if #(.W(16)) bus();

  sigmoid_horner_eval #(.W(16), .FRAC(8), .SAT_INT(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] lut1 [8];
  logic [15:0] lut2 [8];
  logic [15:0] lut3 [8];

  assign bus.t1 = lut1[bus.seg_idx];
  assign bus.t2 = lut2[bus.seg_idx];
  assign bus.t3 = lut3[bus.seg_idx];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_stub(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    for (int i = 0; i < 8; i++) begin
      lut1[i] = a;
      lut2[i] = b;
      lut3[i] = c;
    end
  endtask

  function automatic int wrap16(input longint v);
    longint m;
    m = ((v % 65536) + 65536) % 65536;
    return (m >= 32768) ? int'(m - 65536) : int'(m);
  endfunction

  function automatic int fmul(input int a, input int b);
    longint p, q;
    p = longint'(a) * longint'(b);
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return wrap16(q);
  endfunction

  function automatic void model(input int x, output int y, output int seg);
    int  ax, ip, base, d, acc, acc2, p, c1, c2, c3;
    bit  neg, sat;
    neg  = (x < 0);
    ax   = neg ? -x : x;
    if (ax > 32767) ax = 32767;
    ip   = ax / 256;
    sat  = (ip >= 6);
    seg  = sat ? 0 : ip;
    base = ((ip < 4) ? ip : 4) * 256;
    d    = ax - base;
    c1   = int'($signed(lut1[seg]));
    c2   = int'($signed(lut2[seg]));
    c3   = int'($signed(lut3[seg]));
    acc  = wrap16(c2 + fmul(d, c3));
    acc2 = wrap16(c1 + fmul(d, acc));
    if (sat)             p = 256;
    else if (acc2 < 0)   p = 0;
    else if (acc2 > 256) p = 256;
    else                 p = acc2;
    y = neg ? 256 - p : p;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait", int'(bus.in_ready), 1);
  endtask

  task automatic send(input logic [15:0] x, output int y, output int seg, output int lat);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y   = int'(bus.y_out);
    seg = int'(bus.seg_idx);
  endtask

  task automatic xact(input string tag, input logic [15:0] x, input int ey, input int eseg);
    int y, seg, lat;
    send(x, y, seg, lat);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_seg"}, seg, eseg);
    chk({tag, "_lat"}, lat, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, seg, lat, ey, eseg, first, second;
    logic [15:0] xr;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.out_ready = 1'b1;
    set_stub(16'h00F0, 16'h0010, 16'hFFFD);
    #1;
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_y",         int'(bus.y_out), 0);
    chk("rst_seg",       int'(bus.seg_idx), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 4.5 lands in segment 4 (ip=4), expanding around 4.0 with d=0.5
    xact("pos4p5", 16'h0480, 247, 4);
    xact("neg4p5", 16'hFB80, 9, 4);

    xact("sat_p6",   16'h0600, 256, 0);
    xact("sat_n6",   16'hFA00, 0, 0);
    xact("sat_min",  16'h8000, 0, 0);
    xact("sat_max",  16'h7FFF, 256, 0);

    set_stub(16'h0080, 16'h0000, 16'h0000);
    xact("zero", 16'h0000, 128, 0);

    set_stub(16'h0200, 16'h0010, 16'hFFFD);
    xact("clip_hi", 16'h0100, 256, 1);
    set_stub(16'hFF00, 16'h0010, 16'hFFFD);
    xact("clip_lo", 16'h0100, 0, 1);

    set_stub(16'h00F0, 16'h0010, 16'hFFFD);

    // Initiation interval with in_valid held high and out_ready tied high
    wait_idle();
    bus.in_valid = 1'b1;
    bus.x_in     = 16'h0100;
    first  = -1;
    second = -1;
    for (int c = 0; c < 14; c++) begin
      if (bus.in_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("ii_cycles", second - first, 5);

    // Backpressure
    wait_idle();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x_in      = 16'h0480;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_lat", lat, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.x_in     = 16'h0600;
      @(posedge clk);
      #1;
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_y",     int'(bus.y_out), 247);
      chk("bp_ready", int'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", int'(bus.in_ready), 1);
    chk("bp_release_valid", int'(bus.out_valid), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_no_ghost", int'(bus.in_ready) + 2 * int'(bus.out_valid), 1);
    end

    // Reset while the evaluation sits in EVAL2
    xact("pre_rst", 16'h0480, 247, 4);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.x_in     = 16'h0380;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  int'(bus.in_ready), 1);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_y",         int'(bus.y_out), 0);
    chk("midrst_seg",       int'(bus.seg_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) seen++;
      end
      chk("midrst_no_output", seen, 0);
    end
    model(int'($signed(16'hFD00)), ey, eseg);
    xact("post_rst", 16'hFD00, ey, eseg);

    // Randomized coefficients and activations against the reference model
    for (int n = 0; n < 48; n++) begin
      if (n % 8 == 0) begin
        for (int i = 0; i < 8; i++) begin
          lut1[i] = 16'($urandom_range(0, 16'h0140));
          lut2[i] = 16'($urandom);
          lut3[i] = 16'($urandom);
        end
      end
      if (n % 3 == 0) xr = 16'($urandom);
      else            xr = 16'($signed($urandom_range(0, 16'h0DFF)) - 16'sh0700);
      model(int'($signed(xr)), ey, eseg);
      send(xr, y, seg, lat);
      chk("rnd_y",   y, ey);
      chk("rnd_seg", seg, eseg);
      chk("rnd_lat", lat, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
